// File: rtl/rand_seq_pkg.sv
// Shared types and defaults for the random pattern sequencer.
package rand_seq_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, PLAY, DONE} seq_state_t;

  typedef logic [1:0] sym_t;

  localparam int unsigned DEFAULT_DEPTH       = 8;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 4;

  // Counter width that stays legal when the count range collapses to a single value.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rand_pattern_seq_pattern_buf.sv
// DEPTH x sym_t register file: one synchronous write port, one asynchronous read port.
module pattern_buf
  import rand_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  sym_t                     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output sym_t                     rdata
);

  sym_t mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; every entry is written during capture before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rand_pattern_seq.sv
// Captures DEPTH random symbols, then plays them out with a minimum hold and renderer handshake.
module rand_pattern_seq
  import rand_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               random,
  input  logic                     start,
  input  logic                     ack,
  output logic                     busy,
  output logic                     pat_valid,
  output logic [1:0]               pat_sym,
  output logic [$clog2(DEPTH)-1:0] pat_idx,
  output logic                     done
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned HW = cnt_width(HOLD_CYCLES);

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  seq_state_t    state_q,    state_d;
  logic [IW-1:0] wr_idx_q,   wr_idx_d;
  logic [IW-1:0] rd_idx_q,   rd_idx_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic buf_we;
  sym_t rd_sym;

  pattern_buf #(
    .DEPTH (DEPTH)
  ) u_pattern_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx_q),
    .wdata (random),
    .raddr (rd_idx_q),
    .rdata (rd_sym)
  );

  // NOTE: every signal driven here gets its default first, so no path leaves it unassigned.
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    hold_cnt_d = hold_cnt_q;
    buf_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          wr_idx_d = '0;
        end
      end

      CAPTURE: begin
        buf_we   = 1'b1;
        wr_idx_d = wr_idx_q + 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          state_d    = PLAY;
          rd_idx_d   = '0;
          hold_cnt_d = '0;
        end
      end

      PLAY: begin
        // An early ack is simply dropped; only ack at the saturated hold count advances.
        if (ack && (hold_cnt_q == HOLD_MAX)) begin
          rd_idx_d   = rd_idx_q + 1'b1;
          hold_cnt_d = '0;
          if (rd_idx_q == LAST_IDX) begin
            state_d = DONE;
          end
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Outputs decode registered state only, so there is no combinational path from any input.
  assign busy      = (state_q != IDLE);
  assign pat_valid = (state_q == PLAY);
  assign done      = (state_q == DONE);
  assign pat_idx   = rd_idx_q;
  assign pat_sym   = pat_valid ? rd_sym : 2'b00;

endmodule

// File: tb/tb_rand_pattern_seq.sv
// Self-checking bench for rand_pattern_seq against a symbol-level playback model.
module tb_rand_pattern_seq;
  import rand_seq_pkg::*;

  localparam int DEPTH = 8;
  localparam int HOLD  = 4;
  localparam int IW    = $clog2(DEPTH);
  localparam int RUN_EDGES = DEPTH + DEPTH * HOLD;   // start edge to the edge that enters DONE
  localparam int PERIOD    = RUN_EDGES + 2;          // plus DONE->IDLE and IDLE->CAPTURE

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    random;
  logic          start;
  logic          ack;
  logic          busy;
  logic          pat_valid;
  logic [1:0]    pat_sym;
  logic [IW-1:0] pat_idx;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  sym_t exp_buf [DEPTH];

  rand_pattern_seq #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .random    (random),
    .start     (start),
    .ack       (ack),
    .busy      (busy),
    .pat_valid (pat_valid),
    .pat_sym   (pat_sym),
    .pat_idx   (pat_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; ack = 1'b0; random = 2'd0;
    tick();
    tick();
    checks++;
    if ({busy, pat_valid, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: busy/valid/done=%b expected 000", {busy, pat_valid, done});
    end
    checks++;
    if (pat_idx !== '0 || pat_sym !== 2'd0) begin
      failures++;
      $display("FAIL reset_pat: idx=%0d sym=%0d expected 0/0", pat_idx, pat_sym);
    end
    rst = 1'b1; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_hold: busy=%b expected 0", busy);
    end
  endtask

  // Start edge plus DEPTH capture cycles; fills exp_buf with what was driven.
  task automatic do_capture(input bit preset, input bit start_noise, output int start_cyc);
    start = 1'b1;
    ack   = 1'($urandom_range(0, 1));
    tick();
    start_cyc = cyc;
    for (int i = 0; i < DEPTH; i++) begin
      if (!preset) exp_buf[i] = sym_t'($urandom_range(0, 3));
      random = exp_buf[i];
      start  = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ack    = 1'($urandom_range(0, 1));
      checks++;
      if (busy !== 1'b1 || pat_valid !== 1'b0 || done !== 1'b0 || pat_sym !== 2'd0) begin
        failures++;
        $display("FAIL capture_outputs[%0d]: busy=%b valid=%b done=%b sym=%0d expected 1/0/0/0",
                 i, busy, pat_valid, done, pat_sym);
      end
      tick();
    end
    start = 1'b0;
  endtask

  // Model: a symbol advances at an edge where ack=1 and it has already been shown >= HOLD cycles.
  // mode 0: ack always; mode 1: random ack; mode 2: single early ack on idx 0, then late ack.
  task automatic do_play(input int mode, input int stop_idx, input bit start_noise,
                         output int done_cyc);
    int  exp_idx = 0;
    int  shown   = 1;
    int  budget  = 0;
    bit  a;
    done_cyc = -1;
    while (exp_idx < DEPTH) begin
      if (exp_idx == stop_idx) return;
      checks++;
      if (pat_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          pat_idx !== IW'(exp_idx) || pat_sym !== exp_buf[exp_idx]) begin
        failures++;
        $display("FAIL play[%0d/%0d]: valid=%b busy=%b done=%b idx=%0d sym=%0d expected 1/1/0 idx=%0d sym=%0d",
                 exp_idx, shown, pat_valid, busy, done, pat_idx, pat_sym, exp_idx, exp_buf[exp_idx]);
      end
      case (mode)
        0:       a = 1'b1;
        1:       a = ($urandom_range(0, 2) == 0);
        default: a = (exp_idx == 0) ? (shown == 2 || shown >= 2 * HOLD) : 1'b1;
      endcase
      ack    = a;
      start  = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      random = 2'($urandom_range(0, 3));
      tick();
      budget++;
      if (a && shown >= HOLD) begin
        exp_idx++;
        shown = 1;
      end else begin
        shown++;
      end
      if (budget > 4000) begin
        failures++;
        $display("FAIL play_timeout: idx=%0d still playing after %0d cycles", exp_idx, budget);
        return;
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || pat_valid !== 1'b0 || pat_idx !== '0 || pat_sym !== 2'd0) begin
      failures++;
      $display("FAIL done_cycle: done=%b busy=%b valid=%b idx=%0d sym=%0d expected 1/1/0/0/0",
               done, busy, pat_valid, pat_idx, pat_sym);
    end
    done_cyc = cyc;
    start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    ack   = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pat_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_done: done=%b busy=%b valid=%b expected 0/0/0", done, busy, pat_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_done: done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_playback();
    int s, d;
    exp_buf = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    do_capture(1'b1, 1'b0, s);
    do_play(0, -1, 1'b0, d);
    checks++;
    if (d - s !== RUN_EDGES) begin
      failures++;
      $display("FAIL done_latency: edges=%0d expected %0d", d - s, RUN_EDGES);
    end
    do_capture(1'b0, 1'b0, s);
    do_play(1, -1, 1'b0, d);
  endtask

  task automatic test_early_ack();
    int s, d;
    do_capture(1'b0, 1'b0, s);
    do_play(2, -1, 1'b0, d);
  endtask

  task automatic test_start_ignored();
    int s, d;
    do_capture(1'b0, 1'b1, s);
    do_play(1, -1, 1'b1, d);
    checks++;
    if (d < 0) begin
      failures++;
      $display("FAIL start_noise_done: no done pulse seen, expected one");
    end
  endtask

  task automatic test_reset_in_play();
    int s, d;
    do_capture(1'b0, 1'b0, s);
    do_play(0, 5, 1'b0, d);
    checks++;
    if (pat_idx !== IW'(5)) begin
      failures++;
      $display("FAIL pre_abort_idx: idx=%0d expected 5", pat_idx);
    end
    start = 1'b0; ack = 1'b1; rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if ({busy, pat_valid, done} !== 3'b000 || pat_idx !== '0) begin
      failures++;
      $display("FAIL abort_state: busy/valid/done=%b idx=%0d expected 000/0",
               {busy, pat_valid, done}, pat_idx);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet[%0d]: done=%b busy=%b expected 0/0", i, done, busy);
      end
    end
    do_capture(1'b0, 1'b0, s);
    do_play(1, -1, 1'b0, d);
  endtask

  task automatic test_back_to_back();
    int n_done   = 0;
    int exp_done = 0;
    int last_done = -1;
    bit prev_done = 1'b0;
    bit prev_busy = 1'b1;
    int wait_cnt  = 0;
    for (int t = RUN_EDGES + 1; t <= 100; t += PERIOD) exp_done++;
    start = 1'b1; ack = 1'b1;
    for (int t = 1; t <= 100; t++) begin
      random = 2'($urandom_range(0, 3));
      tick();
      if (busy === 1'b0) begin
        checks++;
        if (prev_done !== 1'b1 || prev_busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_gap@%0d: busy low with prev_done=%b prev_busy=%b expected 1/1",
                   t, prev_done, prev_busy);
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (last_done >= 0) begin
          checks++;
          if (t - last_done !== PERIOD) begin
            failures++;
            $display("FAIL b2b_period: %0d expected %0d", t - last_done, PERIOD);
          end
        end else begin
          checks++;
          if (t !== RUN_EDGES + 1) begin
            failures++;
            $display("FAIL b2b_first_done: at %0d expected %0d", t, RUN_EDGES + 1);
          end
        end
        last_done = t;
      end
      prev_done = done;
      prev_busy = busy;
    end
    checks++;
    if (n_done !== exp_done) begin
      failures++;
      $display("FAIL b2b_count: done pulses=%0d expected %0d", n_done, exp_done);
    end
    start = 1'b0;
    while (busy !== 1'b0 && wait_cnt < 200) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: busy=%b after %0d cycles expected 0", busy, wait_cnt);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ack = 1'b0; random = 2'd0;
    test_reset();
    test_playback();
    test_early_ack();
    test_start_ignored();
    test_reset_in_play();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
